screen_writer: RTL and testbench

SCREEN_WRITER -- requirements
Module: screen_writer

---
 rtl/screen_writer_pkg.sv | 22 ++
 rtl/screen_writer.sv | 180 ++++++++++++++++++
 tb/tb_screen_writer.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/screen_writer_pkg.sv
// Text-screen geometry and control codes shared by screen_writer and the char generator.
package screen_writer_pkg;
   localparam int ROWS          = 24;
   localparam int COLS          = 80;
   localparam int ROW_BITS      = 5;
   localparam int COL_BITS      = 7;
   localparam int ADDR_BITS     = 11;
   localparam int PAST_LAST_ROW = ROWS * COLS;

   localparam logic [7:0] CHAR_SPACE  = 8'h20;
   localparam logic [7:0] CHAR_BS     = 8'h08;
   localparam logic [7:0] CHAR_LF     = 8'h0A;
   localparam logic [7:0] CHAR_CR     = 8'h0D;
   localparam logic [7:0] PRINT_FIRST = 8'h20;
   localparam logic [7:0] PRINT_LAST  = 8'h7E;

   typedef enum logic [1:0] {
      INIT_CLEAR,
      IDLE,
      LINE_CLEAR
   } sw_state_t;
endpackage

// File: rtl/screen_writer.sv
// Turns a byte stream into char-buffer writes and scroll commands for a ROWS x COLS
// text screen whose buffer is a circular array starting at first_char.
module screen_writer #(
   parameter int ROWS      = screen_writer_pkg::ROWS,
   parameter int COLS      = screen_writer_pkg::COLS,
   parameter int ROW_BITS  = screen_writer_pkg::ROW_BITS,
   parameter int COL_BITS  = screen_writer_pkg::COL_BITS,
   parameter int ADDR_BITS = screen_writer_pkg::ADDR_BITS
) (
   input  logic                 clk,
   input  logic                 clr,
   input  logic [7:0]           data,
   input  logic                 valid,
   output logic                 ready,
   output logic [ADDR_BITS-1:0] buffer_waddr,
   output logic [7:0]           buffer_din,
   output logic                 buffer_wen,
   output logic [ADDR_BITS-1:0] buffer_first_char,
   output logic                 buffer_first_char_wen,
   output logic [ROW_BITS-1:0]  cursor_row,
   output logic [COL_BITS-1:0]  cursor_col
);
   import screen_writer_pkg::*;

   localparam int                   BUF_SIZE   = ROWS * COLS;
   localparam logic [ADDR_BITS:0]   BUF_SIZE_W = (ADDR_BITS+1)'(BUF_SIZE);
   localparam logic [ADDR_BITS-1:0] LAST_ADDR  = ADDR_BITS'(BUF_SIZE - 1);
   localparam logic [ADDR_BITS-1:0] COLS_A     = ADDR_BITS'(COLS);
   localparam logic [ADDR_BITS-1:0] LAST_CLEAR = ADDR_BITS'(COLS - 1);
   localparam logic [ROW_BITS-1:0]  LAST_ROW   = ROW_BITS'(ROWS - 1);
   localparam logic [COL_BITS-1:0]  LAST_COL   = COL_BITS'(COLS - 1);

   // Modular add for operands already below BUF_SIZE; wraps at the buffer size, not 2**ADDR_BITS.
   function automatic logic [ADDR_BITS-1:0] wrap_add(input logic [ADDR_BITS-1:0] a,
                                                     input logic [ADDR_BITS-1:0] b);
      logic [ADDR_BITS:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      if (sum >= BUF_SIZE_W)
         sum = sum - BUF_SIZE_W;
      return sum[ADDR_BITS-1:0];
   endfunction

   sw_state_t            state_reg, state_next;
   logic [ADDR_BITS-1:0] fill_cnt_reg, fill_cnt_next;
   logic [ADDR_BITS-1:0] fill_addr_reg, fill_addr_next;
   logic [ADDR_BITS-1:0] first_char_reg, first_char_next;
   logic [ADDR_BITS-1:0] row_base_reg, row_base_next;
   logic [ROW_BITS-1:0]  cursor_row_reg, cursor_row_next;
   logic [COL_BITS-1:0]  cursor_col_reg, cursor_col_next;
   logic                 ready_reg, ready_next;
   logic [ADDR_BITS-1:0] waddr_reg, waddr_next;
   logic [7:0]           din_reg, din_next;
   logic                 wen_reg, wen_next;
   logic [ADDR_BITS-1:0] fc_out_reg, fc_out_next;
   logic                 fc_wen_reg, fc_wen_next;
   logic                 accept;

   assign accept = valid & ready_reg;

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state_reg      <= INIT_CLEAR;
         fill_cnt_reg   <= '0;
         fill_addr_reg  <= '0;
         first_char_reg <= '0;
         row_base_reg   <= '0;
         cursor_row_reg <= '0;
         cursor_col_reg <= '0;
         ready_reg      <= 1'b0;
         waddr_reg      <= '0;
         din_reg        <= CHAR_SPACE;
         wen_reg        <= 1'b0;
         fc_out_reg     <= '0;
         fc_wen_reg     <= 1'b0;
      end else begin
         state_reg      <= state_next;
         fill_cnt_reg   <= fill_cnt_next;
         fill_addr_reg  <= fill_addr_next;
         first_char_reg <= first_char_next;
         row_base_reg   <= row_base_next;
         cursor_row_reg <= cursor_row_next;
         cursor_col_reg <= cursor_col_next;
         ready_reg      <= ready_next;
         waddr_reg      <= waddr_next;
         din_reg        <= din_next;
         wen_reg        <= wen_next;
         fc_out_reg     <= fc_out_next;
         fc_wen_reg     <= fc_wen_next;
      end
   end

   always_comb begin
      state_next      = state_reg;
      fill_cnt_next   = fill_cnt_reg;
      fill_addr_next  = fill_addr_reg;
      first_char_next = first_char_reg;
      row_base_next   = row_base_reg;
      cursor_row_next = cursor_row_reg;
      cursor_col_next = cursor_col_reg;
      ready_next      = 1'b0;
      waddr_next      = waddr_reg;
      din_next        = din_reg;
      wen_next        = 1'b0;
      fc_out_next     = fc_out_reg;
      fc_wen_next     = 1'b0;

      case (state_reg)
         INIT_CLEAR: begin
            wen_next   = 1'b1;
            waddr_next = fill_cnt_reg;
            din_next   = CHAR_SPACE;
            if (fill_cnt_reg == LAST_ADDR) begin
               fill_cnt_next = '0;
               state_next    = IDLE;
            end else begin
               fill_cnt_next = fill_cnt_reg + ADDR_BITS'(1);
            end
         end

         LINE_CLEAR: begin
            wen_next       = 1'b1;
            waddr_next     = fill_addr_reg;
            din_next       = CHAR_SPACE;
            fill_addr_next = wrap_add(fill_addr_reg, ADDR_BITS'(1));
            if (fill_cnt_reg == LAST_CLEAR) begin
               fill_cnt_next = '0;
               state_next    = IDLE;
            end else begin
               fill_cnt_next = fill_cnt_reg + ADDR_BITS'(1);
            end
         end

         IDLE: begin
            // ready is registered, so it first rises the cycle after the last clear write.
            ready_next = 1'b1;
            if (accept) begin
               if (data >= PRINT_FIRST && data <= PRINT_LAST) begin
                  wen_next   = 1'b1;
                  waddr_next = wrap_add(row_base_reg, ADDR_BITS'(cursor_col_reg));
                  din_next   = data;
                  if (cursor_col_reg != LAST_COL)
                     cursor_col_next = cursor_col_reg + COL_BITS'(1);
               end else if (data == CHAR_CR) begin
                  cursor_col_next = '0;
               end else if (data == CHAR_BS) begin
                  if (cursor_col_reg != '0)
                     cursor_col_next = cursor_col_reg - COL_BITS'(1);
               end else if (data == CHAR_LF) begin
                  row_base_next = wrap_add(row_base_reg, COLS_A);
                  if (cursor_row_reg != LAST_ROW) begin
                     cursor_row_next = cursor_row_reg + ROW_BITS'(1);
                  end else begin
                     // Scroll: the old top row becomes the new bottom row and is blanked.
                     first_char_next = wrap_add(first_char_reg, COLS_A);
                     fc_out_next     = wrap_add(first_char_reg, COLS_A);
                     fc_wen_next     = 1'b1;
                     fill_addr_next  = first_char_reg;
                     fill_cnt_next   = '0;
                     ready_next      = 1'b0;
                     state_next      = LINE_CLEAR;
                  end
               end
            end
         end

         default: begin
            state_next = INIT_CLEAR;
         end
      endcase
   end

   assign ready                 = ready_reg;
   assign buffer_waddr          = waddr_reg;
   assign buffer_din            = din_reg;
   assign buffer_wen            = wen_reg;
   assign buffer_first_char     = fc_out_reg;
   assign buffer_first_char_wen = fc_wen_reg;
   assign cursor_row            = cursor_row_reg;
   assign cursor_col            = cursor_col_reg;
endmodule

// File: tb/tb_screen_writer.sv
// Directed bench for screen_writer: init clear, printing, control codes, scrolling, reset abort.
module tb_screen_writer;
   logic        clk;
   logic        clr;
   logic [7:0]  data;
   logic        valid;
   logic        ready;
   logic [10:0] buffer_waddr;
   logic [7:0]  buffer_din;
   logic        buffer_wen;
   logic [10:0] buffer_first_char;
   logic        buffer_first_char_wen;
   logic [4:0]  cursor_row;
   logic [6:0]  cursor_col;

   int total = 0;
   int bad   = 0;

   screen_writer dut (
      .clk                   (clk),
      .clr                   (clr),
      .data                  (data),
      .valid                 (valid),
      .ready                 (ready),
      .buffer_waddr          (buffer_waddr),
      .buffer_din            (buffer_din),
      .buffer_wen            (buffer_wen),
      .buffer_first_char     (buffer_first_char),
      .buffer_first_char_wen (buffer_first_char_wen),
      .cursor_row            (cursor_row),
      .cursor_col            (cursor_col)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
      end else begin
         $display("ok   %s: %0d", tag, got);
      end
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_ready"}, ready, 0);
      check({tag, "_wen"}, buffer_wen, 0);
      check({tag, "_fc_wen"}, buffer_first_char_wen, 0);
      check({tag, "_waddr"}, buffer_waddr, 0);
      check({tag, "_din"}, buffer_din, 32);
      check({tag, "_fc"}, buffer_first_char, 0);
      check({tag, "_row"}, cursor_row, 0);
      check({tag, "_col"}, cursor_col, 0);
   endtask

   // Called at the negedge where clr was released; follows the whole init clear.
   task automatic init_check(input string tag);
      int n    = 0;
      int err  = 0;
      int cyc  = 0;
      int last = -10;
      while (!ready && cyc < 2100) begin
         @(negedge clk);
         cyc++;
         if (buffer_wen) begin
            if (buffer_waddr != n || buffer_din != 8'h20 || (n > 0 && last != cyc - 1))
               err++;
            n++;
            last = cyc;
         end
         if (buffer_first_char_wen) err++;
      end
      check({tag, "_writes"}, n, 1920);
      check({tag, "_seq_err"}, err, 0);
      check({tag, "_ready"}, ready, 1);
      check({tag, "_ready_lat"}, cyc - last, 1);
   endtask

   // Waits (bounded) for ready, transfers one byte, returns at the negedge after acceptance.
   task automatic send(input logic [7:0] b);
      int w = 0;
      while (!ready && w < 300) begin
         @(negedge clk);
         w++;
      end
      if (w >= 300) check("send_ready_timeout", ready, 1);
      data  = b;
      valid = 1'b1;
      @(negedge clk);
      valid = 1'b0;
      data  = 8'h00;
   endtask

   task automatic do_scroll(input int exp_fc, input int old_fc);
      int n   = 0;
      int err = 0;
      int cyc = 0;
      send(8'h0A);
      check("scroll_fc_wen", buffer_first_char_wen, 1);
      check("scroll_fc", buffer_first_char, exp_fc);
      check("scroll_no_wen", buffer_wen, 0);
      check("scroll_ready_low", ready, 0);
      while (!ready && cyc < 200) begin
         @(negedge clk);
         cyc++;
         if (buffer_wen) begin
            if (buffer_waddr != (old_fc + n) % 1920 || buffer_din != 8'h20) err++;
            n++;
         end
         if (ready && buffer_wen) err++;
         if (buffer_first_char_wen) err++;
      end
      check("scroll_clear_writes", n, 80);
      check("scroll_clear_err", err, 0);
      check("scroll_ready_back", ready, 1);
      check("scroll_row", cursor_row, 23);
      check("scroll_col", cursor_col, 0);
   endtask

   initial begin
      clr   = 1'b1;
      data  = 8'h00;
      valid = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_state("reset");

      clr = 1'b0;
      init_check("init");

      send(8'h41);
      check("A_wen", buffer_wen, 1);
      check("A_addr", buffer_waddr, 0);
      check("A_din", buffer_din, 8'h41);
      check("A_row", cursor_row, 0);
      check("A_col", cursor_col, 1);

      send(8'h0D);
      check("cr_no_wen", buffer_wen, 0);
      check("cr_col", cursor_col, 0);
      send(8'h0A);
      send(8'h0A);
      check("lf_no_wen", buffer_wen, 0);
      check("lf_row", cursor_row, 2);

      for (int i = 0; i < 79; i++) send(8'h2E);
      check("fill_col", cursor_col, 79);
      send(8'h42);
      check("sat1_wen", buffer_wen, 1);
      check("sat1_addr", buffer_waddr, 239);
      check("sat1_din", buffer_din, 8'h42);
      check("sat1_col", cursor_col, 79);
      check("sat1_ready", ready, 1);
      send(8'h43);
      check("sat2_wen", buffer_wen, 1);
      check("sat2_addr", buffer_waddr, 239);
      check("sat2_din", buffer_din, 8'h43);
      check("sat2_col", cursor_col, 79);

      send(8'h0D);
      send(8'h08);
      check("bs0_no_wen", buffer_wen, 0);
      check("bs0_col", cursor_col, 0);
      send(8'h07);
      check("bel_no_wen", buffer_wen, 0);
      check("bel_waddr_hold", buffer_waddr, 239);
      check("bel_din_hold", buffer_din, 8'h43);
      check("bel_row", cursor_row, 2);
      check("bel_col", cursor_col, 0);
      for (int i = 0; i < 5; i++) send(8'h61);
      check("five_col", cursor_col, 5);
      send(8'h08);
      check("bs_col", cursor_col, 4);
      send(8'h30);
      check("bs_write_addr", buffer_waddr, 164);
      send(8'h0D);
      check("cr5_no_wen", buffer_wen, 0);
      check("cr5_row", cursor_row, 2);
      check("cr5_col", cursor_col, 0);

      for (int i = 0; i < 21; i++) send(8'h0A);
      check("row23", cursor_row, 23);

      do_scroll(80, 0);
      send(8'h41);
      check("wrap_A_wen", buffer_wen, 1);
      check("wrap_A_addr", buffer_waddr, 0);
      send(8'h0D);

      for (int k = 2; k <= 23; k++) do_scroll((80 * k) % 1920, 80 * (k - 1));
      do_scroll(0, 1840);
      send(8'h41);
      check("last_A_wen", buffer_wen, 1);
      check("last_A_addr", buffer_waddr, 1840);
      check("last_A_din", buffer_din, 8'h41);
      send(8'h0D);

      send(8'h0A);
      check("abort_fc_wen", buffer_first_char_wen, 1);
      repeat (5) @(negedge clk);
      check("abort_mid_clear_wen", buffer_wen, 1);
      clr = 1'b1;
      @(negedge clk);
      check_reset_state("abort");
      clr = 1'b0;
      init_check("reinit");

      send(8'h41);
      check("post_A_addr", buffer_waddr, 0);
      check("post_A_row", cursor_row, 0);
      check("post_A_col", cursor_col, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
